fc_chunk_accum: RTL and testbench

//  Parametrised fully-connected stage fed by the conv array one chunk per beat (CHUNK activations).

---
 rtl/fc_chunk_accum.sv | 140 ++++++++++++++
 tb/tb_fc_chunk_accum.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_chunk_accum.sv
// rtl/fc_chunk_accum.sv - chunked fully-connected stage: MAC over beats, bias, optional ReLU, argmax
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_in_valid/o_in_ready         input beat handshake, i_in_data = CHUNK activations
//   i_flush                       abort the partial frame (ignored while a result is held)
//   o_w_addr/i_w_data             weight slice index for the next beat, weights returned same cycle
//   i_bias, i_relu                per-neuron bias (sampled on last beat), ReLU enable (sampled on first beat)
//   o_out_valid/i_out_ready       result handshake, o_out_data = NUM_OUT results, o_argmax = largest index
module fc_chunk_accum #(
    parameter int CHUNK      = 26,
    parameter int NUM_CHUNKS = 26,
    parameter int NUM_OUT    = 10,
    parameter int IN_W       = 16,
    parameter int W_W        = 8,
    parameter int ACC_W      = 32,
    localparam int AW        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
    localparam int OW        = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [CHUNK*IN_W-1:0]      i_in_data,
    input  logic                       i_flush,
    output logic [AW-1:0]              o_w_addr,
    input  logic [NUM_OUT*CHUNK*W_W-1:0] i_w_data,
    input  logic [NUM_OUT*ACC_W-1:0]   i_bias,
    input  logic                       i_relu,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [NUM_OUT*ACC_W-1:0]   o_out_data,
    output logic [OW-1:0]              o_argmax
);

    localparam int PW = IN_W + W_W;
    localparam logic [0:0] S_ACC  = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]                r_state;
    logic [AW-1:0]             r_w_addr;
    logic signed [ACC_W-1:0]   r_acc [NUM_OUT];
    logic                      r_relu;
    logic                      r_out_valid;
    logic [NUM_OUT*ACC_W-1:0]  r_out_data;
    logic [OW-1:0]             r_argmax;

    logic                      w_in_ready;
    logic                      w_in_fire;
    logic                      w_out_fire;
    logic                      w_first;
    logic                      w_last;
    logic                      w_relu_eff;
    logic signed [ACC_W-1:0]   w_next_acc [NUM_OUT];
    logic signed [ACC_W-1:0]   w_res [NUM_OUT];
    logic [OW-1:0]             w_argmax;

    assign w_in_ready = (r_state == S_ACC) && !i_flush;
    assign w_in_fire  = i_in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && i_out_ready;
    assign w_first    = (r_w_addr == '0);
    assign w_last     = (r_w_addr == AW'(NUM_CHUNKS - 1));
    // On the first beat the ReLU flag has not been latched yet; with a
    // one-beat frame that beat is also the last, so use the live input.
    assign w_relu_eff = w_first ? i_relu : r_relu;

    always_comb begin
        logic signed [PW-1:0]    v_prod;
        logic signed [ACC_W-1:0] v_sum;
        logic signed [ACC_W-1:0] v_best;
        v_prod = '0;
        v_sum  = '0;
        for (int n = 0; n < NUM_OUT; n++) begin
            v_sum = '0;
            for (int k = 0; k < CHUNK; k++) begin
                v_prod = $signed(i_in_data[k*IN_W +: IN_W]) * $signed(i_w_data[(n*CHUNK+k)*W_W +: W_W]);
                v_sum  = v_sum + {{(ACC_W-PW){v_prod[PW-1]}}, v_prod};
            end
            w_next_acc[n] = r_acc[n] + v_sum;
            w_res[n]      = w_next_acc[n] + $signed(i_bias[n*ACC_W +: ACC_W]);
            if (w_relu_eff && w_res[n][ACC_W-1]) begin
                w_res[n] = '0;
            end
        end
        // Strictly-greater keeps the lowest index on ties.
        w_argmax = '0;
        v_best   = w_res[0];
        for (int n = 1; n < NUM_OUT; n++) begin
            if (w_res[n] > v_best) begin
                v_best   = w_res[n];
                w_argmax = OW'(n);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_ACC;
            r_w_addr    <= '0;
            r_relu      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_argmax    <= '0;
            for (int n = 0; n < NUM_OUT; n++) r_acc[n] <= '0;
        end else begin
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_state     <= S_ACC;
            end
            if (r_state == S_ACC) begin
                if (i_flush) begin
                    r_w_addr <= '0;
                    for (int n = 0; n < NUM_OUT; n++) r_acc[n] <= '0;
                end else if (w_in_fire) begin
                    if (w_first) r_relu <= i_relu;
                    if (w_last) begin
                        for (int n = 0; n < NUM_OUT; n++) begin
                            r_out_data[n*ACC_W +: ACC_W] <= w_res[n];
                            r_acc[n] <= '0;
                        end
                        r_argmax    <= w_argmax;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                        r_w_addr    <= '0;
                    end else begin
                        for (int n = 0; n < NUM_OUT; n++) r_acc[n] <= w_next_acc[n];
                        r_w_addr <= r_w_addr + AW'(1);
                    end
                end
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_w_addr    = r_w_addr;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_argmax    = r_argmax;

endmodule

// File: tb/tb_fc_chunk_accum.sv
// tb/tb_fc_chunk_accum.sv - scoreboard bench for fc_chunk_accum at default parameters
module tb_fc_chunk_accum;

    localparam int CHUNK = 26, NC = 26, NO = 10, IN_W = 16, W_W = 8, ACC_W = 32;
    localparam int AW = $clog2(NC), OW = $clog2(NO);
    localparam int DW = NO * ACC_W;

    logic                 i_clk = 0, i_rst = 1, i_in_valid = 0, i_flush = 0, i_relu = 0, i_out_ready = 0;
    logic                 o_in_ready, o_out_valid;
    logic [CHUNK*IN_W-1:0] i_in_data = '0;
    logic [AW-1:0]        o_w_addr;
    logic [NO*CHUNK*W_W-1:0] i_w_data;
    logic [DW-1:0]        i_bias = '0, o_out_data;
    logic [OW-1:0]        o_argmax;

    fc_chunk_accum #(.CHUNK(CHUNK), .NUM_CHUNKS(NC), .NUM_OUT(NO), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_data(i_in_data), .i_flush(i_flush), .o_w_addr(o_w_addr), .i_w_data(i_w_data),
        .i_bias(i_bias), .i_relu(i_relu), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_data(o_out_data), .o_argmax(o_argmax));

    always #5 i_clk = ~i_clk;

    typedef struct { logic [DW-1:0] data; logic [OW-1:0] am; } exp_t;
    exp_t sb[$];

    logic signed [W_W-1:0]   w_mem [NC][NO][CHUNK];
    logic signed [IN_W-1:0]  act [NC][CHUNK];
    logic signed [ACC_W-1:0] bias_v [NO];

    int  checks = 0, errors = 0;
    bit  hold_ready = 0, rand_mode = 0;

    // combinational weight ROM addressed by the DUT
    always_comb begin
        i_w_data = '0;
        if (int'(o_w_addr) < NC)
            for (int n = 0; n < NO; n++)
                for (int k = 0; k < CHUNK; k++)
                    i_w_data[(n*CHUNK+k)*W_W +: W_W] = w_mem[o_w_addr][n][k];
    end

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Dot products computed directly from the frame arrays with 64-bit arithmetic,
    // then truncated to the accumulator width.
    function automatic exp_t model(input bit relu);
        exp_t e;
        longint s;
        logic signed [ACC_W-1:0] r, best;
        e.data = '0; e.am = '0; best = '0;
        for (int n = 0; n < NO; n++) begin
            s = 0;
            for (int c = 0; c < NC; c++)
                for (int k = 0; k < CHUNK; k++)
                    s += longint'(act[c][k]) * longint'(w_mem[c][n][k]);
            s += longint'(bias_v[n]);
            r = s[ACC_W-1:0];
            if (relu && r < 0) r = 0;
            e.data[n*ACC_W +: ACC_W] = r;
            if (n == 0 || r > best) begin best = r; e.am = OW'(n); end
        end
        return e;
    endfunction

    task automatic drive_beat(input int c, input bit relu, input bit last);
        bit rdy, done;
        if (rand_mode) repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
        for (int k = 0; k < CHUNK; k++) i_in_data[k*IN_W +: IN_W] = act[c][k];
        i_relu = (c == 0) ? relu : 1'($urandom);
        for (int n = 0; n < NO; n++) i_bias[n*ACC_W +: ACC_W] = last ? bias_v[n] : ACC_W'($urandom);
        i_in_valid = 1;
        done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge i_clk);
            rdy = o_in_ready;
            if (rdy) chk("w_addr", DW'(o_w_addr), DW'(c));
            @(posedge i_clk); #1;
            done = rdy;
        end
        if (!done) chk("beat_timeout", 0, 1);
        i_in_valid = 0;
    endtask

    task automatic run_frame(input bit relu);
        sb.push_back(model(relu));
        for (int c = 0; c < NC; c++) drive_beat(c, relu, c == NC - 1);
    endtask

    task automatic wait_valid();
        bit seen = 0;
        for (int t = 0; t < 300 && !seen; t++) begin @(negedge i_clk); seen = o_out_valid; end
        if (!seen) chk("valid_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        @(posedge i_clk); #1 i_rst = 1;
        @(posedge i_clk); #1 i_rst = 0;
        sb.delete();
        @(negedge i_clk);
        chk("rst_valid", DW'(o_out_valid), 0);
        chk("rst_addr", DW'(o_w_addr), 0);
        chk("rst_ready", DW'(o_in_ready), 1);
    endtask

    task automatic fill_const(input int a, input int w0, input int w1, input int wr);
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < CHUNK; k++) begin
                act[c][k] = IN_W'(a);
                for (int n = 0; n < NO; n++) w_mem[c][n][k] = W_W'(n == 0 ? w0 : n == 1 ? w1 : wr);
            end
    endtask

    task automatic fill_random();
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < CHUNK; k++) begin
                act[c][k] = IN_W'($urandom);
                for (int n = 0; n < NO; n++) w_mem[c][n][k] = W_W'($urandom);
            end
        for (int n = 0; n < NO; n++) bias_v[n] = ACC_W'($urandom);
    endtask

    // output ready driver
    initial forever begin
        @(posedge i_clk); #1;
        i_out_ready = hold_ready ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // monitor: pops the scoreboard on each output handshake, checks hold stability
    initial begin
        exp_t e;
        logic [DW-1:0] prev_d;
        logic [OW-1:0] prev_a;
        bit prev_hold = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst) prev_hold = 0;
            else if (o_out_valid) begin
                chk("hold_in_ready", DW'(o_in_ready), 0);
                if (prev_hold) begin
                    chk("hold_data", o_out_data, prev_d);
                    chk("hold_argmax", DW'(o_argmax), DW'(prev_a));
                end
                if (i_out_ready) begin
                    prev_hold = 0;
                    if (sb.size() == 0) chk("unexpected_out", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("out_data", o_out_data, e.data);
                        chk("argmax", DW'(o_argmax), DW'(e.am));
                    end
                end else begin
                    prev_hold = 1; prev_d = o_out_data; prev_a = o_argmax;
                end
            end else prev_hold = 0;
        end
    end

    initial begin
        for (int n = 0; n < NO; n++) bias_v[n] = '0;
        fill_const(0, 0, 0, 0);
        repeat (3) @(posedge i_clk);
        #1 i_rst = 0;
        @(negedge i_clk);
        chk("rst_valid", DW'(o_out_valid), 0);
        chk("rst_addr", DW'(o_w_addr), 0);
        chk("rst_ready", DW'(o_in_ready), 1);
        chk("rst_data", o_out_data, 0);
        chk("rst_argmax", DW'(o_argmax), 0);
        @(posedge i_clk); #1;

        // all ones -> 676 per neuron, tie -> argmax 0
        fill_const(1, 1, 1, 1);
        run_frame(0);
        // signed patterns, ReLU on and off
        fill_const(-5, 1, -1, 0);
        bias_v[1] = 10;
        run_frame(1);
        run_frame(0);
        fill_const(-3, 2, 1, 3);
        for (int n = 0; n < NO; n++) bias_v[n] = ACC_W'(n * 7);
        run_frame(0);
        wait_valid();

        // backpressure: result held, next frame only after release
        for (int n = 0; n < NO; n++) bias_v[n] = '0;
        fill_const(2, 1, 3, -1);
        hold_ready = 1;
        run_frame(0);
        wait_valid();
        repeat (5) @(negedge i_clk);
        @(posedge i_clk); #1 hold_ready = 0;
        fill_const(1, 1, 1, 1);
        run_frame(0);

        // flush after two beats, then a clean frame
        drive_beat(0, 0, 0);
        drive_beat(1, 0, 0);
        i_flush = 1; i_in_valid = 1;
        @(negedge i_clk);
        chk("flush_ready", DW'(o_in_ready), 0);
        @(posedge i_clk); #1 i_flush = 0; i_in_valid = 0;
        @(negedge i_clk);
        chk("flush_addr", DW'(o_w_addr), 0);
        @(posedge i_clk); #1;
        run_frame(0);
        wait_valid();

        // reset while holding a result, then mid-frame
        fill_random();
        hold_ready = 1;
        run_frame(1);
        wait_valid();
        hold_ready = 0;
        pulse_reset();
        @(posedge i_clk); #1;
        for (int c = 0; c < 5; c++) drive_beat(c, 0, 0);
        pulse_reset();
        @(posedge i_clk); #1;
        run_frame(0);

        // randomized frames with random backpressure
        rand_mode = 1;
        for (int f = 0; f < 100; f++) begin
            fill_random();
            run_frame(1'($urandom));
        end

        for (int t = 0; t < 2000 && sb.size() != 0; t++) @(posedge i_clk);
        if (sb.size() != 0) chk("drain", DW'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
